// File: rtl/multicycle_controller.sv
// Moore sequencing controller for the multicycle RV32I core: steps the shared ALU,
// memory port and register file through fetch/decode/execute/memory/writeback.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_OLD  = 2'b01;
  localparam logic [1:0] SRC_A_RD1  = 2'b10;
  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  state_t  state;
  state_t  state_nxt;
  alu_op_t alu_op;
  logic    pc_update;
  logic    branch;
  logic    taken;

  function automatic state_t decode_next(input logic [6:0] opc);
    case (opc)
      OP_LOAD, OP_STORE: return MEMADR;
      OP_R:              return EXECR;
      OP_I:              return EXECI;
      OP_JAL:            return JAL;
      OP_BRANCH:         return BRANCH;
      default:           return ILLEGAL;
    endcase
  endfunction

  // Subtract only for R-type sub; I-type addi reuses bit 30 as an immediate bit.
  function automatic logic [2:0] alu_decode(input alu_op_t aop, input logic [2:0] f3,
                                            input logic op5, input logic f7b5);
    case (aop)
      ALU_ADD: return 3'b000;
      ALU_SUB: return 3'b001;
      default: begin
        case (f3)
          3'b000:  return (op5 & f7b5) ? 3'b001 : 3'b000;
          3'b010:  return 3'b101;
          3'b110:  return 3'b011;
          3'b111:  return 3'b010;
          default: return 3'b000;
        endcase
      end
    endcase
  endfunction

  function automatic logic [1:0] imm_decode(input logic [6:0] opc);
    case (opc)
      OP_STORE:  return 2'b01;
      OP_BRANCH: return 2'b10;
      OP_JAL:    return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:    if (mem_ready) state_nxt = DECODE;
      DECODE:   state_nxt = decode_next(op);
      MEMADR:   state_nxt = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_nxt = MEMWB;
      MEMWRITE: if (mem_ready) state_nxt = FETCH;
      MEMWB, ALUWB, BRANCH: state_nxt = FETCH;
      EXECR, EXECI, JAL:    state_nxt = ALUWB;
      ILLEGAL:  state_nxt = ILLEGAL;
      default:  state_nxt = FETCH;
    endcase
  end

  // Outputs decode from state; mem_ready only gates the fetch/store handshakes.
  always_comb begin
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RD2;
    alu_op      = ALU_ADD;
    reg_write   = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    imm_src     = imm_decode(op);
    case (state)
      FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRC_A_OLD;
        alu_src_b = SRC_B_IMM;
      end
      MEMADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
      end
      EXECR: begin
        alu_src_a = SRC_A_RD1;
        alu_op    = ALU_FUNCT;
      end
      EXECI: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      JAL: begin
        alu_src_a = SRC_A_OLD;
        alu_src_b = SRC_B_FOUR;
        pc_update = 1'b1;
      end
      BRANCH: begin
        alu_src_a = SRC_A_RD1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      ILLEGAL: begin
        illegal = 1'b1;
        imm_src = 2'b00;
      end
      default: ;
    endcase
    taken       = zero ^ funct3[0];
    alu_control = alu_decode(alu_op, funct3, op[5], funct7b5);
    pc_write    = pc_update | (branch & taken);
    // Reset must kill every strobe in the same cycle, not at the next edge.
    if (!rst_n) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      imm_src     = 2'b00;
      reg_write   = 1'b0;
      retire      = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle stimulus and expected
// output vectors are queued, then driven and compared cycle by cycle.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [17:0] outs;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
  } cyc_t;

  cyc_t        stim_q[$];
  logic [17:0] exp_q[$];

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .retire(retire), .illegal(illegal)
  );

  assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, alu_control, imm_src, reg_write, retire, illegal};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mw,
      input logic irw, input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
      input logic [2:0] alu, input logic [1:0] imm, input logic rw, input logic ret,
      input logic ill);
    return {pcw, adr, mw, irw, rs, a, b, alu, imm, rw, ret, ill};
  endfunction

  function automatic logic [17:0] v_fetch(input logic r, input logic [1:0] imm);
    return pk(r, 0, 0, r, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_decode(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_memadr(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_memread(input logic [1:0] imm);
    return pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_memwb(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, imm, 1, 1, 0);
  endfunction
  function automatic logic [17:0] v_memwrite(input logic r, input logic [1:0] imm);
    return pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0, r, 0);
  endfunction
  function automatic logic [17:0] v_execr(input logic [2:0] alu, input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, imm, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_execi(input logic [2:0] alu, input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, imm, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_aluwb(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 1, 0);
  endfunction
  function automatic logic [17:0] v_jal(input logic [1:0] imm);
    return pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, imm, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_branch(input logic t, input logic [1:0] imm);
    return pk(t, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 0, 1, 0);
  endfunction
  function automatic logic [17:0] v_illegal();
    return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 1);
  endfunction

  task automatic put(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic rdy, input logic [17:0] e);
    cyc_t c;
    c.op = o; c.f3 = f3; c.f7 = f7; c.z = z; c.rdy = rdy; c.exp = e;
    stim_q.push_back(c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = OP_STORE; mem_ready = 1'b1; zero = 1'b1;
    funct3 = 3'b111; funct7b5 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (outs !== 18'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", outs, 18'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== v_fetch(0, 2'b01)) begin
      bad++; $display("FAIL reset_state_fetch got=%h want=%h", outs, v_fetch(0, 2'b01));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [2:0] f3s [9] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b000, 3'b010, 3'b111};
    logic       f7s [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] alus[9] = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b010, 3'b000, 3'b000, 3'b101, 3'b010};
    cyc_t c;
    logic [17:0] e;
    int n = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        put(OP_R, f3s[i], f7s[i], 0, 1, v_fetch(1, 2'b00));
        put(OP_R, f3s[i], f7s[i], 0, 1, v_decode(2'b00));
        put(OP_R, f3s[i], f7s[i], 0, 1, v_execr(alus[i], 2'b00));
        put(7'b0000000, f3s[i], f7s[i], 0, 1, v_aluwb(2'b00));
      end else begin
        put(OP_I, f3s[i], f7s[i], 0, 1, v_fetch(1, 2'b00));
        put(OP_I, f3s[i], f7s[i], 0, 1, v_decode(2'b00));
        put(OP_I, f3s[i], f7s[i], 0, 1, v_execi(alus[i], 2'b00));
        put(OP_I, f3s[i], f7s[i], 0, 1, v_aluwb(2'b00));
      end
    end
    while (stim_q.size() > 0) begin
      c = stim_q.pop_front();
      op = c.op; funct3 = c.f3; funct7b5 = c.f7; zero = c.z; mem_ready = c.rdy;
      exp_q.push_back(c.exp);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++; $display("FAIL alu cyc=%0d got=%h want=%h", n, outs, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_mem();
    cyc_t c;
    logic [17:0] e;
    int n = 0;
    put(OP_LOAD, 3'b010, 0, 0, 1, v_fetch(1, 2'b00));
    put(OP_LOAD, 3'b010, 0, 0, 1, v_decode(2'b00));
    put(OP_LOAD, 3'b010, 0, 0, 1, v_memadr(2'b00));
    put(OP_LOAD, 3'b010, 0, 0, 0, v_memread(2'b00));
    put(OP_LOAD, 3'b010, 0, 0, 0, v_memread(2'b00));
    put(OP_LOAD, 3'b010, 0, 0, 1, v_memread(2'b00));
    put(OP_LOAD, 3'b010, 0, 0, 1, v_memwb(2'b00));
    put(OP_STORE, 3'b010, 0, 0, 1, v_fetch(1, 2'b01));
    put(OP_STORE, 3'b010, 0, 0, 1, v_decode(2'b01));
    put(OP_STORE, 3'b010, 0, 0, 1, v_memadr(2'b01));
    put(OP_STORE, 3'b010, 0, 0, 1, v_memwrite(1, 2'b01));
    put(OP_STORE, 3'b010, 0, 0, 1, v_fetch(1, 2'b01));
    put(OP_STORE, 3'b010, 0, 0, 1, v_decode(2'b01));
    put(OP_STORE, 3'b010, 0, 0, 1, v_memadr(2'b01));
    put(OP_STORE, 3'b010, 0, 0, 0, v_memwrite(0, 2'b01));
    put(OP_STORE, 3'b010, 0, 0, 1, v_memwrite(1, 2'b01));
    while (stim_q.size() > 0) begin
      c = stim_q.pop_front();
      op = c.op; funct3 = c.f3; funct7b5 = c.f7; zero = c.z; mem_ready = c.rdy;
      exp_q.push_back(c.exp);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++; $display("FAIL mem cyc=%0d got=%h want=%h", n, outs, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_control_flow();
    logic [2:0] f3s[4] = '{3'b000, 3'b001, 3'b001, 3'b000};
    logic       zs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    cyc_t c;
    logic [17:0] e;
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      put(OP_BRANCH, f3s[i], 0, zs[i], 1, v_fetch(1, 2'b10));
      put(OP_BRANCH, f3s[i], 0, zs[i], 1, v_decode(2'b10));
      put(OP_BRANCH, f3s[i], 0, zs[i], 1, v_branch(tk[i], 2'b10));
    end
    put(OP_JAL, 3'b000, 0, 0, 1, v_fetch(1, 2'b11));
    put(OP_JAL, 3'b000, 0, 0, 1, v_decode(2'b11));
    put(OP_JAL, 3'b000, 0, 0, 1, v_jal(2'b11));
    put(OP_JAL, 3'b000, 0, 0, 1, v_aluwb(2'b11));
    while (stim_q.size() > 0) begin
      c = stim_q.pop_front();
      op = c.op; funct3 = c.f3; funct7b5 = c.f7; zero = c.z; mem_ready = c.rdy;
      exp_q.push_back(c.exp);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++; $display("FAIL ctrl_flow cyc=%0d got=%h want=%h", n, outs, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_fetch_stall();
    cyc_t c;
    logic [17:0] e;
    int n = 0;
    for (int i = 0; i < 3; i++) put(OP_I, 3'b000, 0, 0, 0, v_fetch(0, 2'b00));
    put(OP_I, 3'b000, 0, 0, 1, v_fetch(1, 2'b00));
    put(OP_I, 3'b000, 0, 0, 0, v_decode(2'b00));
    put(OP_I, 3'b000, 0, 0, 0, v_execi(3'b000, 2'b00));
    put(OP_I, 3'b000, 0, 0, 0, v_aluwb(2'b00));
    while (stim_q.size() > 0) begin
      c = stim_q.pop_front();
      op = c.op; funct3 = c.f3; funct7b5 = c.f7; zero = c.z; mem_ready = c.rdy;
      exp_q.push_back(c.exp);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++; $display("FAIL fetch_stall cyc=%0d got=%h want=%h", n, outs, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    logic [17:0] e;
    int n = 0;
    put(7'b0000000, 3'b000, 0, 0, 1, v_fetch(1, 2'b00));
    put(7'b0000000, 3'b000, 0, 0, 1, v_decode(2'b00));
    for (int i = 0; i < 10; i++)
      put(7'b0000000, 3'($urandom_range(7)), 1'($urandom_range(1)),
          1'($urandom_range(1)), 1'($urandom_range(1)), v_illegal());
    while (stim_q.size() > 0) begin
      c = stim_q.pop_front();
      op = c.op; funct3 = c.f3; funct7b5 = c.f7; zero = c.z; mem_ready = c.rdy;
      exp_q.push_back(c.exp);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++; $display("FAIL illegal cyc=%0d got=%h want=%h", n, outs, e);
      end
      @(posedge clk); #1;
      n++;
    end
    rst_n = 1'b0;
    #2;
    total++;
    if (outs !== 18'd0) begin
      bad++; $display("FAIL illegal_reset_outs got=%h want=%h", outs, 18'd0);
    end
    rst_n = 1'b1; op = OP_R; mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== v_fetch(0, 2'b00)) begin
      bad++; $display("FAIL illegal_reset_fetch got=%h want=%h", outs, v_fetch(0, 2'b00));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_reset();
    cyc_t c;
    logic [17:0] e;
    int n = 0;
    put(OP_STORE, 3'b010, 0, 0, 1, v_fetch(1, 2'b01));
    put(OP_STORE, 3'b010, 0, 0, 1, v_decode(2'b01));
    put(OP_STORE, 3'b010, 0, 0, 1, v_memadr(2'b01));
    put(OP_STORE, 3'b010, 0, 0, 0, v_memwrite(0, 2'b01));
    while (stim_q.size() > 0) begin
      c = stim_q.pop_front();
      op = c.op; funct3 = c.f3; funct7b5 = c.f7; zero = c.z; mem_ready = c.rdy;
      exp_q.push_back(c.exp);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++; $display("FAIL store_reset cyc=%0d got=%h want=%h", n, outs, e);
      end
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (mem_write !== 1'b1) begin
      bad++; $display("FAIL store_wait_mem_write got=%b want=1", mem_write);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (outs !== 18'd0) begin
      bad++; $display("FAIL store_reset_same_cycle got=%h want=%h", outs, 18'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== v_fetch(0, 2'b01)) begin
      bad++; $display("FAIL store_reset_fetch got=%h want=%h", outs, v_fetch(0, 2'b01));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_control_flow();
    test_fetch_stall();
    test_illegal();
    test_store_reset();
    test_alu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle RV32I core. It replaces the single-cycle decode path with a Moore state machine that steps one shared ALU, one shared memory port and the register file through fetch, decode, execute, memory and writeback. An internal ALU-control decode turns funct3/funct7 into ALU operations. It supports LOAD, STORE, R-type, I-type ALU, BRANCH (beq/bne) and JAL, with a memory-ready handshake on every memory access.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; rising edge active
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode from the instruction register
- funct3  in  3  instruction bits [14:12]
- funct7b5  in  1  instruction bit 30
- zero  in  1  ALU zero flag; valid in the BRANCH state
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = result
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register and old-PC enable
- result_src  out  2  result mux select: 00 = alu_out, 01 = read data, 10 = alu_result
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old_pc, 10 = rd1
- alu_src_b  out  2  ALU B select: 00 = rd2, 01 = imm, 10 = constant 4
- alu_control  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  high while the controller is halted on an unsupported opcode

## Operation
- States, 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, ILLEGAL=11.
- Outputs are a function of state, except the mem_ready gating and pc_write, which are noted below. Any output not listed for a state is 0.
- FETCH: adr_src=0, a=00, b=10, alu_op add, result_src=10.
  - ir_write=1 and pc_update=1 only when mem_ready=1.
  - Advance to DECODE on mem_ready; otherwise hold in FETCH.
- DECODE: a=01, b=01, add (precomputes the branch target into alu_out).
  - Next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1101111 -> JAL, 1100011 -> BRANCH.
  - Any other opcode -> ILLEGAL.
- MEMADR: a=10, b=01, add. Go to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Advance to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1, retire=1. Go to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held while waiting.
  - On mem_ready: retire=1, go to FETCH.
- EXECR: a=10, b=00, alu_op funct. Go to ALUWB.
- EXECI: a=10, b=01, alu_op funct. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1. Go to FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_update=1. Go to ALUWB.
- BRANCH: a=10, b=00, sub, result_src=00, retire=1. Go to FETCH.
  - Taken = zero XOR funct3[0] (beq/bne).
- ILLEGAL: illegal=1 and all other outputs 0. Held until reset.
- pc_write = pc_update | (BRANCH & taken).
- ALU decode:
  - alu_op add -> 000; sub -> 001.
  - funct, by funct3: 000 -> sub if op[5]&funct7b5, else add; 010 -> 101; 110 -> 011; 111 -> 010.
  - Any other funct3 -> 000.
- imm_src comes combinationally from op in all states: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.

## Timing
- The state register updates on the clk rising edge; outputs are combinational from state and inputs.
- rst_n low: state goes to FETCH immediately (asynchronously). Every output is forced to 0 while rst_n is low, including ir_write and mem_write.
  - After rst_n deasserts, the first edge with mem_ready=1 performs the first fetch.
- Latency in cycles, mem_ready tied high: LOAD 5, STORE 4, R 4, I 4, JAL 4, BRANCH 3.
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Side effects per instruction: exactly one ir_write pulse and at most one retire pulse. pc_write pulses once (twice for JAL).
- Reset mid-instruction: a pending mem_write or reg_write drops in the same cycle. No partial state survives.
- op is sampled at DECODE and MEMADR only. Changes to op in other states do not affect sequencing.

## Test plan
- add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0), mem_ready=1 -> states 0,1,6,7; alu_control=000 in EXECR; reg_write and retire in cycle 4 only.
- lw (op 0000011), mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4; reg_write once with result_src=01; 7 cycles total.
- beq with zero=1, then bne with zero=1 -> pc_write=1 in BRANCH for the first, pc_write=0 for the second; each takes 3 cycles.
- FETCH with mem_ready=0 for 3 cycles, then 1 -> ir_write and pc_write are 1 only in the 4th cycle.
- op=0000000 at DECODE -> ILLEGAL; illegal=1 and all other outputs 0 for 10 cycles; rst_n pulse returns the controller to FETCH.
- sw with mem_ready=0 in MEMWRITE and rst_n asserted mid-wait -> mem_write falls to 0 the same cycle; state is FETCH; no retire.
